alu_req_arbiter: RTL
====================

Name: alu_req_arbiter

Overview:
- Two-requester front end for the shared 64-bit ALU datapath (AND/OR/XOR/ADD/SUB/SHL/SHR).
- Arbitrates requests round-robin and keeps one operation in flight.
- Drives the ALU select, carry-in and operand lines, holds them for a fixed latency, then captures the result.
- Computes C/Z/O/N flags from the captured result and returns it on a single response channel with valid/ready.

Parameters:
- WIDTH, 64, operand/result width; flag logic uses bit WIDTH-1 as the sign.
- ALU_LAT, 1, cycles the ALU inputs are held before sampling; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op / req1_op  in  3  opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SHL, 6 SHR, 7 reserved.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands; the shift amount is b[5:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester index of the response.
- rsp_data  out  WIDTH  result.
- rsp_flags  out  4  {C,Z,O,N} (bit3 = C).
- rsp_err  out  1  reserved opcode.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_sel  out  8  [0] invert A, [1] invert B, [4:2] result mux (0 AND, 1 OR, 2 XOR, 3 ADD, 4 SHL, 5 SHR), [7:5] = 0.
- alu_cin  out  1  adder carry-in.
- alu_out  in  WIDTH  ALU result.
- alu_cout  in  1  adder carry-out.

Behaviour:
- Reset: asynchronous on rst_n low.
  - Outputs go to 0: state IDLE, all ready/valid/data/flags/err, and all alu_* lines.
  - Round-robin pointer favours req0.
  - Reset mid-operation abandons it: no response is issued, and req*_ready stays 0 until rst_n is released.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready is combinational and asserted only in IDLE, for exactly one requester.
  - Winner: if only one valid, that one; if both valid, the one the pointer favours.
  - On handshake: latch op, a, b and id; the pointer then favours the other requester.
  - Valid opcode goes to EXEC with count = ALU_LAT-1.
  - Reserved opcode goes straight to RESP with rsp_data=0, rsp_flags=0, rsp_err=1; the ALU is never driven.
- EXEC:
  - alu_a/alu_b/alu_sel/alu_cin are driven from the latched registers, stable for exactly ALU_LAT cycles.
  - Op mapping: AND sel=0x00; OR 0x04; XOR 0x08; ADD 0x0C, cin=0; SUB 0x0E (invert B, ADD), cin=1; SHL 0x10; SHR 0x14.
  - On the cycle with count==0: register rsp_data=alu_out and the flags, then go to RESP. Otherwise decrement count.
  - ALU lines return to 0 outside EXEC.
- Flags, computed from the sampled result r:
  - Z = (r==0).
  - N = r[WIDTH-1].
  - C = alu_cout for ADD/SUB, else 0. For SUB, C=1 means no borrow.
  - O for ADD = (a[msb]==b[msb]) & (r[msb]!=a[msb]).
  - O for SUB = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
  - O = 0 for all other ops.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_flags/rsp_err are held stable until rsp_valid&rsp_ready.
  - On that handshake go to IDLE; rsp_valid drops the next cycle.
  - No new request is accepted in the handshake cycle.
- Latency: request handshake at cycle T gives rsp_valid at T+1+ALU_LAT. Minimum issue interval is ALU_LAT+2 cycles.
- Requesters must hold valid and operands stable until ready; a request that is not granted waits with no timeout.

Test Plan:
- ADD overflow: req0 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, ALU_LAT=1.
  - alu_sel=0x0C, alu_cin=0 for 1 cycle.
  - Response: data 0x8000_0000_0000_0000, flags C0 Z0 O1 N1, rsp_id=0, rsp_valid 2 cycles after handshake.
- SUB borrow and zero:
  - req1 SUB 5-7 → data 0xFFFF_FFFF_FFFF_FFFE, flags C0 Z0 O0 N1, alu_sel=0x0E, cin=1.
  - Then SUB 7-7 → data 0, flags C1 Z1 O0 N0.
- Round-robin: both requesters hold valid continuously with distinct ADDs.
  - Grants alternate 0,1,0,1; rsp_id sequence matches.
  - The loser's ready stays 0 until the next IDLE.
- Backpressure with ALU_LAT=3: SHL a=1, b=63.
  - ALU lines held exactly 3 cycles.
  - rsp_ready held low 5 cycles: rsp_valid and data 0x8000_0000_0000_0000 stay stable, no req ready asserted.
  - Release: handshake, then IDLE.
- Reserved op 7: no EXEC cycle, alu_sel stays 0x00; response 1 cycle after handshake with err=1, data 0, flags 0.
- Reset mid-EXEC (ALU_LAT=4, rst_n low at 2nd EXEC cycle):
  - All outputs 0 immediately.
  - No response after release.
  - Next simultaneous request is granted to req0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: two-requester round-robin front end for a shared ALU datapath.
// Keeps one operation in flight. The ALU lines are held for ALU_LAT cycles,
// the result is sampled, C/Z/O/N flags are derived, and a single response
// goes back to the winning requester.
//
// Handshake rule for every channel here (req0, req1, rsp): a transfer happens
// on a rising clock edge where valid and ready are both high. The producer
// holds valid and payload stable until that edge, and ready never depends on
// the same channel's payload.
module alu_req_arbiter #(
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  // shared ALU datapath
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [7:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  // debug view of the control FSM (0 IDLE, 1 EXEC, 2 RESP)
  output logic [1:0]       dbg_state
);

  // Requester opcodes
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  // Counter start value: EXEC lasts exactly ALU_LAT cycles
  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);
  localparam int         MSB      = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // FSM and registered outputs
  state_e           state_q;
  logic             rr_q;        // 0: req0 favoured on a tie, 1: req1 favoured
  logic [3:0]       cnt_q;
  logic [2:0]       op_q;
  logic             a_msb_q;     // operand sign bits kept for the overflow flag
  logic             b_msb_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [7:0]       alu_sel_q;
  logic             alu_cin_q;

  // Arbitration and next-value signals
  logic             idle_act;
  logic             grant0;
  logic             grant1;
  logic             hs;
  logic             win_id;
  logic [2:0]       win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [7:0]       sel_d;
  logic             cin_d;
  logic             flag_c_d;
  logic             flag_z_d;
  logic             flag_o_d;
  logic             flag_n_d;
  logic [3:0]       flags_d;

  // Map a requester opcode onto the ALU select word:
  // [0] invert A, [1] invert B, [4:2] result mux, [7:5] unused (0)
  function automatic logic [7:0] sel_for(input logic [2:0] op);
    logic [7:0] s;
    case (op)
      OP_AND:  s = 8'h00;
      OP_OR:   s = 8'h04;
      OP_XOR:  s = 8'h08;
      OP_ADD:  s = 8'h0C;
      OP_SUB:  s = 8'h0E;  // A + ~B + 1
      OP_SHL:  s = 8'h10;
      OP_SHR:  s = 8'h14;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Grant: only while IDLE and out of reset; a lone requester wins, a tie goes to rr_q
  always_comb begin
    idle_act = (state_q == S_IDLE) && rst_n;
    grant0   = idle_act && req0_valid && (!req1_valid || !rr_q);
    grant1   = idle_act && req1_valid && (!req0_valid ||  rr_q);
    hs       = grant0 || grant1;
    win_id   = grant1;
    win_op   = grant1 ? req1_op : req0_op;
    win_a    = grant1 ? req1_a  : req0_a;
    win_b    = grant1 ? req1_b  : req0_b;
    sel_d    = sel_for(win_op);
    cin_d    = (win_op == OP_SUB);
  end

  // Flags from the sampled ALU result; carry and overflow only for ADD/SUB
  always_comb begin
    flag_c_d = 1'b0;
    flag_o_d = 1'b0;
    flag_z_d = (alu_out == '0);
    flag_n_d = alu_out[MSB];
    if (op_q == OP_ADD) begin
      flag_c_d = alu_cout;
      flag_o_d = (a_msb_q == b_msb_q) && (alu_out[MSB] != a_msb_q);
    end else if (op_q == OP_SUB) begin
      flag_c_d = alu_cout;  // 1 means no borrow
      flag_o_d = (a_msb_q != b_msb_q) && (alu_out[MSB] != a_msb_q);
    end
    flags_d = {flag_c_d, flag_z_d, flag_o_d, flag_n_d};
  end

  // Control FSM with all outputs registered; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      op_q        <= OP_AND;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_cin_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hs) begin
            rr_q     <= ~win_id;
            op_q     <= win_op;
            a_msb_q  <= win_a[MSB];
            b_msb_q  <= win_b[MSB];
            rsp_id_q <= win_id;
            if (win_op == OP_RSV) begin
              // Reserved opcode never touches the ALU
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_flags_q <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q   <= S_EXEC;
              cnt_q     <= CNT_INIT;
              alu_a_q   <= win_a;
              alu_b_q   <= win_b;
              alu_sel_q <= sel_d;
              alu_cin_q <= cin_d;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_out;
            rsp_flags_q <= flags_d;
            rsp_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_cin_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign alu_cin    = alu_cin_q;
  assign dbg_state  = state_q;

endmodule
